// File: rtl/rv32i_tb_pkg.sv
// Shared types and defaults for the RV32I simulation/bring-up run controller.
package rv32i_tb_pkg;

  typedef enum logic [1:0] {StHold, StRun, StDone} run_state_t;

  localparam int unsigned DefDataW      = 32;
  localparam int unsigned DefCntW       = 16;
  localparam int unsigned DefRstCycles  = 4;
  localparam int unsigned DefTimeout    = 25;
  localparam int unsigned DefHaltRepeat = 4;

  // Widest word rotl1 handles; callers narrower than this zero-extend and truncate.
  localparam int unsigned RotMaxW = 64;

  function automatic logic [RotMaxW-1:0] rotl1(input logic [RotMaxW-1:0] x,
                                               input int unsigned w);
    logic [RotMaxW-1:0] mask;
    mask = {RotMaxW{1'b1}} >> (RotMaxW - w);
    return ((x << 1) | (x >> (w - 1))) & mask;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Two-flop reset synchroniser: asynchronous assert, synchronous release.
module reset_sync (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_sync_no
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_sync_no = sync_q[1];

endmodule

// File: rtl/run_ctrl.sv
// Core run controller: stretches core reset, counts run cycles, detects halt/timeout
// from the write-back bus and keeps a rotate-xor write-back signature.
module run_ctrl
  import rv32i_tb_pkg::*;
#(
  parameter int unsigned       DATA_W      = DefDataW,
  parameter int unsigned       CNT_W       = DefCntW,
  parameter int unsigned       RST_CYCLES  = DefRstCycles,
  parameter int unsigned       TIMEOUT     = DefTimeout,
  parameter int unsigned       HALT_REPEAT = DefHaltRepeat,
  parameter logic [DATA_W-1:0] PASS_VALUE  = DATA_W'(1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic [DATA_W-1:0] wb_in,
  output logic              core_reset,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycles,
  output logic [DATA_W-1:0] checksum,
  output logic [DATA_W-1:0] last_wb
);

  localparam int unsigned      RepW       = $clog2(HALT_REPEAT + 1);
  localparam int unsigned      HoldW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLast   = HoldW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
  localparam logic [RepW-1:0]  HaltRep    = RepW'(HALT_REPEAT);

  logic rst_sync;

  reset_sync u_reset_sync (
    .clk_i       (clk),
    .rst_ni      (reset),
    .rst_sync_no (rst_sync)
  );

  run_state_t        state_q, state_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic [DATA_W-1:0] last_wb_q, last_wb_d;
  logic [RepW-1:0]   rep_q, rep_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StHold;
      hold_cnt_q <= '0;
      cycles_q   <= '0;
      checksum_q <= '0;
      last_wb_q  <= '0;
      rep_q      <= '0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      cycles_q   <= cycles_d;
      checksum_q <= checksum_d;
      last_wb_q  <= last_wb_d;
      rep_q      <= rep_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cycles_d   = cycles_q;
    checksum_d = checksum_q;
    last_wb_d  = last_wb_q;
    rep_d      = rep_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;

    unique case (state_q)
      StHold: begin
        if (rst_sync) begin
          if (hold_cnt_q == HoldLast) begin
            state_d    = StRun;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end

      StRun: begin
        cycles_d   = cycles_q + 1'b1;
        checksum_d = DATA_W'(rotl1(RotMaxW'(checksum_q), DATA_W)) ^ wb_in;
        last_wb_d  = wb_in;
        // rep_q is zero only on the first sample of a run, so last_wb is not yet meaningful.
        if ((rep_q != '0) && (wb_in == last_wb_q)) begin
          rep_d = rep_q + 1'b1;
        end else begin
          rep_d = RepW'(1);
        end
        // Halt takes priority over a timeout landing on the same sample.
        if (rep_d == HaltRep) begin
          state_d   = StDone;
          pass_d    = (wb_in == PASS_VALUE);
          timeout_d = 1'b0;
        end else if (cycles_d == TimeoutCnt) begin
          state_d   = StDone;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
        end
      end

      StDone: begin
        if (restart) begin
          state_d    = StHold;
          hold_cnt_d = '0;
          cycles_d   = '0;
          checksum_d = '0;
          last_wb_d  = '0;
          rep_d      = '0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
        end
      end

      default: begin
        state_d = StHold;
      end
    endcase
  end

  assign core_reset = (state_q != StRun);
  assign running    = (state_q == StRun);
  assign done       = (state_q == StDone);
  assign pass       = pass_q;
  assign timeout    = timeout_q;
  assign cycles     = cycles_q;
  assign checksum   = checksum_q;
  assign last_wb    = last_wb_q;

endmodule
